reaction_game_ctrl: RTL and testbench
=====================================

# reaction_game_ctrl

Top-level sequencer for the reaction-time game. Drives the 2-bit `state` bus consumed by the countdown block: it loads the LFSR-generated delay, waits for the countdown's `done`, then lights the stimulus LED. It measures the player's response in clock ticks (1 ms at the 1 kHz game clock) and tracks the best time. It also flags early presses and timeouts.

## Interface
- `MAX_REACT`, 999: reaction-count ceiling in ticks. Reaching it is a timeout. Must be < 2^`TW`-1.
- `TW`, 10: width of the reaction-time and best-time registers.
- `clock` in 1: the 1 kHz game clock, shared with the countdown block.
- `reset_n` in 1: asynchronous, active-low reset.
- `button` in 1: raw player pushbutton, asynchronous to `clock`.
- `done` in 1: countdown-finished flag from the countdown block.
- `state` out 2: phase bus to the countdown block. Encoding: 0 = IDLE, 1 = LOAD, 2 = WAIT, 3 = REACT.
- `led` out 1: stimulus light. High only in REACT.
- `reaction_time` out TW: last measured response, held until the next measurement.
- `result_valid` out 1: one-cycle pulse when `reaction_time` updates.
- `best_time` out TW: minimum valid `reaction_time` since reset. All-ones means no result yet.
- `early` out 1: sticky flag, set when the button is pressed during WAIT.
- `timeout` out 1: sticky flag, set when REACT reaches `MAX_REACT`.

## Operation
- Button conditioning: 2-flop synchronizer, then a third flop for edge detection. `press` = sync2 & ~sync3, one cycle wide. Only `press` is used by the FSM.
- IDLE, `state`=0: on `press`, clear `early` and `timeout`, then go to LOAD.
- LOAD, `state`=1: lasts exactly one cycle, then WAIT. The countdown block captures its start value while `state`=1.
- WAIT, `state`=2:
  - `press` → set `early`, go to IDLE.
  - `done` and no `press` → clear the reaction counter, go to REACT.
  - If `press` and `done` arrive in the same cycle, `press` wins and the round is an early fault.
- REACT, `state`=3, `led`=1. The reaction counter increments every cycle from 0.
  - `press` → `reaction_time` ← counter value, pulse `result_valid`. If that value < `best_time`, then `best_time` ← value. Go to IDLE.
  - Counter == `MAX_REACT` with no `press` → set `timeout`, `reaction_time` ← `MAX_REACT`. No `result_valid` pulse and no `best_time` update. Go to IDLE.
  - If `press` arrives in the same cycle the counter hits `MAX_REACT`, it counts as a valid press.
- The reaction counter never wraps. It is only compared, never incremented past `MAX_REACT`.
- Reset, asynchronous, any time:
  - `state`=IDLE, `led`=0, `result_valid`=0, `early`=0, `timeout`=0.
  - `reaction_time`=0, `best_time`=all-ones.
  - Synchronizer flops = 0.
- Reset mid-round aborts the round with no result.

## Timing
- All outputs are registered and change only on the `clock` rising edge, except during reset.
- Raw `button` rise to `press`: 2–3 cycles. The FSM reacts in the same edge that `press` is high.
- `done` high in WAIT → `state`=3 and `led`=1 on the next edge.
- Reported `reaction_time` counts the full cycles from `led` rising to the `press` edge. It includes synchronizer latency, and no compensation is applied.
- `result_valid` is high for exactly one cycle, coincident with the first cycle of IDLE.
- A held button produces no further `press` until it is released and pressed again.

## Structure
- Shared package holds the state encoding constants (IDLE/LOAD/WAIT/REACT = 0/1/2/3), used by both this block and the countdown block, plus the default `MAX_REACT`.
- One natural sub-module: `button_sync_edge` (synchronizer plus rising-edge pulse). It is reusable for other pushbuttons on the board.

## Test plan
- Reset, then press; countdown asserts `done` after 5 cycles; press raised 120 cycles after `led` rises → `reaction_time` = 120 + sync latency (fixed, checked once). `result_valid` pulses once, `best_time` equals it, `state` returns to 0.
- Second round with a slower press (200 cycles) → `reaction_time` updates, `best_time` is unchanged. A third round at 50 cycles → `best_time` updates.
- Press during WAIT → `early`=1, `state`=0, `led` never rises, no `result_valid`. The next IDLE press clears `early`.
- No press in REACT → after `MAX_REACT` cycles `timeout`=1, `reaction_time`=999, `best_time` is unchanged.
- `press` and `done` in the same WAIT cycle → early fault. Separately, a button held across two rounds triggers only one start.
- Assert `reset_n` low mid-REACT → all outputs take their reset values immediately, `best_time`=all-ones.

Source files
------------

// File: rtl/reaction_game_ctrl_pkg.sv
// Shared definitions for the reaction-time game: phase encoding seen by the
// countdown block and default sizing of the reaction counter.
package reaction_game_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_REACT = 2'd3
  } game_state_e;

  localparam int unsigned DEFAULT_MAX_REACT = 999;
  localparam int unsigned DEFAULT_TW        = 10;

endpackage

// File: rtl/reaction_game_ctrl_if.sv
// Game-controller signal bundle: player/countdown inputs and result outputs.
interface reaction_game_ctrl_if #(
  parameter int unsigned TW = 10
);

  logic          button;
  logic          done;
  logic [1:0]    state;
  logic          led;
  logic [TW-1:0] reaction_time;
  logic          result_valid;
  logic [TW-1:0] best_time;
  logic          early;
  logic          timeout;

  modport master (
    input  button, done,
    output state, led, reaction_time, result_valid, best_time, early, timeout
  );

  modport slave (
    output button, done,
    input  state, led, reaction_time, result_valid, best_time, early, timeout
  );

endinterface

// File: rtl/reaction_game_ctrl_button_sync_edge.sv
// Two-flop synchronizer for an asynchronous pushbutton followed by a
// rising-edge detector producing a single-cycle press pulse.
module button_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_async,
  output logic press
);

  // [0],[1] form the synchronizer; [2] is the delayed copy for edge detection
  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], btn_async};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign press = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction-game sequencer: drives the countdown phase bus, lights the stimulus
// LED, measures response time and tracks best time plus early/timeout faults.
module reaction_game_ctrl
  import reaction_game_ctrl_pkg::*;
#(
  parameter int unsigned MAX_REACT = DEFAULT_MAX_REACT,
  parameter int unsigned TW        = DEFAULT_TW
) (
  input  logic                 clock,
  input  logic                 reset_n,
  reaction_game_ctrl_if.master bus
);

  localparam logic [TW-1:0] MAX_T = TW'(MAX_REACT);

  logic press;

  game_state_e   state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] rt_q, rt_d;
  logic [TW-1:0] best_q, best_d;
  logic          rv_q, rv_d;
  logic          early_q, early_d;
  logic          to_q, to_d;
  logic          led_q, led_d;

  button_sync_edge u_btn (
    .clk       (clock),
    .rst_n     (reset_n),
    .btn_async (bus.button),
    .press     (press)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rt_d    = rt_q;
    best_d  = best_q;
    rv_d    = 1'b0;
    early_d = early_q;
    to_d    = to_q;

    case (state_q)
      ST_IDLE: begin
        if (press) begin
          early_d = 1'b0;
          to_d    = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_WAIT;
      ST_WAIT: begin
        // a press coinciding with done is still an early fault
        if (press) begin
          early_d = 1'b1;
          state_d = ST_IDLE;
        end else if (bus.done) begin
          cnt_d   = '0;
          state_d = ST_REACT;
        end
      end
      ST_REACT: begin
        if (press) begin
          rt_d    = cnt_q;
          rv_d    = 1'b1;
          if (cnt_q < best_q) begin
            best_d = cnt_q;
          end
          state_d = ST_IDLE;
        end else if (cnt_q == MAX_T) begin
          to_d    = 1'b1;
          rt_d    = MAX_T;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // led is registered from the next phase so it tracks state exactly
    led_d = (state_d == ST_REACT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rt_q    <= '0;
      best_q  <= '1;
      rv_q    <= 1'b0;
      early_q <= 1'b0;
      to_q    <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rt_q    <= rt_d;
      best_q  <= best_d;
      rv_q    <= rv_d;
      early_q <= early_d;
      to_q    <= to_d;
      led_q   <= led_d;
    end
  end

  assign bus.state         = state_q;
  assign bus.led           = led_q;
  assign bus.reaction_time = rt_q;
  assign bus.result_valid  = rv_q;
  assign bus.best_time     = best_q;
  assign bus.early         = early_q;
  assign bus.timeout       = to_q;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Self-checking bench for reaction_game_ctrl: table-driven rounds with a
// result scoreboard, plus hand-written early/timeout/held-button/reset cases.
module tb_reaction_game_ctrl;

  localparam int unsigned TW        = 10;
  localparam int unsigned MAX_REACT = 999;
  // button raised just after edge k is seen by the FSM at edge k+3 with counter k+2
  localparam int unsigned SYNC_LAT  = 2;

  typedef struct {
    int unsigned   delay;
    logic [TW-1:0] exp_rt;
    logic [TW-1:0] exp_best;
  } vec_t;

  typedef struct {
    logic [TW-1:0] rt;
    logic [TW-1:0] best;
  } exp_t;

  logic clk;
  logic rst_n;
  int unsigned checks;
  int unsigned errors;
  int unsigned rv_count;
  exp_t sb[$];
  vec_t vecs[3];

  reaction_game_ctrl_if #(.TW(TW)) bus ();

  reaction_game_ctrl #(
    .MAX_REACT (MAX_REACT),
    .TW        (TW)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic wait_state(input logic [1:0] tgt, input int unsigned budget, input string nm);
    int unsigned n = 0;
    while (bus.state !== tgt && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, 32'(bus.state), 32'(tgt));
  endtask

  // button high for exactly one sampling cycle; returns #1 after the next edge
  task automatic pulse_button();
    bus.button = 1'b1;
    @(posedge clk);
    #1;
    bus.button = 1'b0;
  endtask

  // scoreboard: compare every result_valid pulse against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && bus.result_valid === 1'b1) begin
      rv_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: reaction_time=%0d with no expected result", bus.reaction_time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_reaction_time", 32'(bus.reaction_time), 32'(e.rt));
        chk("sb_best_time", 32'(bus.best_time), 32'(e.best));
      end
    end
  end

  initial begin
    vecs[0] = '{delay: 120, exp_rt: 10'd122, exp_best: 10'd122};
    vecs[1] = '{delay: 200, exp_rt: 10'd202, exp_best: 10'd122};
    vecs[2] = '{delay: 50,  exp_rt: 10'd52,  exp_best: 10'd52};

    checks   = 0;
    errors   = 0;
    rv_count = 0;
    rst_n    = 1'b0;
    bus.button = 1'b0;
    bus.done   = 1'b0;

    #12;
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_led", 32'(bus.led), 0);
    chk("rst_reaction_time", 32'(bus.reaction_time), 0);
    chk("rst_best_time", 32'(bus.best_time), 32'h3FF);
    chk("rst_result_valid", 32'(bus.result_valid), 0);
    chk("rst_early", 32'(bus.early), 0);
    chk("rst_timeout", 32'(bus.timeout), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // normal rounds
    for (int i = 0; i < 3; i++) begin
      int unsigned rv_before;
      pulse_button();
      wait_state(2'd1, 6, "round_load");
      @(posedge clk);
      #1;
      chk("round_wait", 32'(bus.state), 2);
      repeat (4) @(posedge clk);
      #1;
      bus.done = 1'b1;
      @(posedge clk);
      #1;
      bus.done = 1'b0;
      chk("round_react_state", 32'(bus.state), 3);
      chk("round_led_on", 32'(bus.led), 1);
      repeat (vecs[i].delay) @(posedge clk);
      #1;
      sb.push_back('{rt: vecs[i].exp_rt, best: vecs[i].exp_best});
      rv_before = rv_count;
      pulse_button();
      wait_state(2'd0, 6, "round_idle");
      chk("round_rv_high", 32'(bus.result_valid), 1);
      chk("round_led_off", 32'(bus.led), 0);
      @(posedge clk);
      #1;
      chk("round_rv_low", 32'(bus.result_valid), 0);
      chk("round_rv_once", rv_count - rv_before, 1);
    end

    // early press during WAIT
    pulse_button();
    wait_state(2'd2, 8, "early_wait");
    pulse_button();
    wait_state(2'd0, 6, "early_idle");
    chk("early_flag", 32'(bus.early), 1);
    chk("early_led", 32'(bus.led), 0);
    chk("early_rt_held", 32'(bus.reaction_time), 52);

    // next press clears early; then press and done land in the same cycle
    pulse_button();
    wait_state(2'd1, 6, "clear_load");
    chk("early_cleared", 32'(bus.early), 0);
    wait_state(2'd2, 4, "tie_wait");
    bus.button = 1'b1;
    @(posedge clk);
    #1;
    bus.button = 1'b0;
    @(posedge clk);
    #1;
    bus.done = 1'b1;
    @(posedge clk);
    #1;
    bus.done = 1'b0;
    chk("tie_state", 32'(bus.state), 0);
    chk("tie_early", 32'(bus.early), 1);
    chk("tie_led", 32'(bus.led), 0);

    // button held through a full round: timeout, and no second start
    bus.button = 1'b1;
    wait_state(2'd2, 8, "held_wait");
    repeat (5) @(posedge clk);
    #1;
    bus.done = 1'b1;
    wait_state(2'd3, 3, "held_react");
    bus.done = 1'b0;
    wait_state(2'd0, MAX_REACT + 10, "held_timeout_idle");
    chk("timeout_flag", 32'(bus.timeout), 1);
    chk("timeout_rt", 32'(bus.reaction_time), MAX_REACT);
    chk("timeout_best", 32'(bus.best_time), 52);
    chk("timeout_no_rv", 32'(bus.result_valid), 0);
    repeat (20) @(posedge clk);
    #1;
    chk("held_no_restart", 32'(bus.state), 0);
    bus.button = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // new round clears timeout; reset mid-REACT
    pulse_button();
    wait_state(2'd1, 6, "rst_round_load");
    chk("timeout_cleared", 32'(bus.timeout), 0);
    wait_state(2'd2, 4, "rst_round_wait");
    bus.done = 1'b1;
    wait_state(2'd3, 3, "rst_round_react");
    bus.done = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_state", 32'(bus.state), 0);
    chk("midrst_led", 32'(bus.led), 0);
    chk("midrst_rt", 32'(bus.reaction_time), 0);
    chk("midrst_best", 32'(bus.best_time), 32'h3FF);
    chk("midrst_rv", 32'(bus.result_valid), 0);
    chk("midrst_early", 32'(bus.early), 0);
    chk("midrst_timeout", 32'(bus.timeout), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(bus.state), 0);
    chk("sb_drained", sb.size(), 0);
    chk("total_results", rv_count, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
